nios_basic_led_fader: RTL and testbench
=======================================

# nios_basic_led_fader

Downstream stage of the Nios basic system's 4-bit LED PIO: consumes the PIO's `out_port` nibble and drives the board LEDs with PWM, ramping each channel's brightness linearly toward full-on or full-off rather than switching abruptly. Runs in the PIO's clock domain, with no bus interface of its own. Software keeps writing plain on/off bits; this block turns each bit change into a fade.

## Interface
- `CHANNELS`, default 4: number of LED channels; matches the PIO width.
- `PWM_BITS`, default 8: duty/counter width; `PWM_MAX` = 2^PWM_BITS − 1.
- `STEP_DIV`, default 50000: clock cycles per fade step; must be ≥ 1.
- `clk`  in  1: system clock, shared with the PIO.
- `reset`  in  1: asynchronous, active-high reset.
- `level`  in  CHANNELS: target per channel, from the PIO `out_port`. 1 = on, 0 = off.
- `fade_en`  in  1: 1 = ramp duty; 0 = duty jumps straight to target.
- `led`  out  CHANNELS: registered PWM outputs to the pins.
- `busy`  out  1: registered; 1 while any channel's duty ≠ its target.

## Operation
- `level` is registered into `level_q` each cycle. Target for channel i is `PWM_MAX` if `level_q[i]` is 1, else 0.
- **Prescaler**
  - Counts 0..STEP_DIV−1 and wraps.
  - `step_tick` is asserted for one cycle when the count equals STEP_DIV−1.
  - If STEP_DIV = 1, `step_tick` is asserted every cycle.
- **Duty register (per channel, PWM_BITS wide)**, evaluated each cycle in priority order:
  1. If `fade_en` = 0: duty ← target.
  2. Else, on `step_tick`: if duty < target, duty + 1; if duty > target, duty − 1; otherwise hold.
  3. Otherwise: hold.
  - Duty never over/underflows; it saturates exactly at 0 and `PWM_MAX`.
- **Per-channel state**: IDLE_OFF (duty = 0), RISING, IDLE_ON (duty = `PWM_MAX`), FALLING.
  - The state is derived from duty vs target; no separate state register is required.
  - A target reversal mid-ramp (RISING→FALLING or back) continues from the current duty with no restart.
- **PWM counter**
  - Shared by all channels; counts 0..PWM_MAX−1 and wraps, giving a period of `PWM_MAX` cycles.
  - `led[i]` ← (`pwm_cnt` < duty[i]).
  - Duty 0 → always off; duty `PWM_MAX` → always on; duty d → on for d cycles per period.
- `busy` ← OR over channels of (duty ≠ target), computed from next-state values, registered.

## Timing
- Reset values: `level_q` = 0, all duty = 0, prescaler = 0, `pwm_cnt` = 0, `led` = 0, `busy` = 0.
- Reset asserted mid-fade clears all of the above immediately (asynchronous). After release, the block resumes toward the current `level`.
- **Latency from `level` edge (cycle k) to `level_q` (k+1)**
  - With `fade_en` = 0: duty at k+2, `led` reflects it at k+3.
  - With `fade_en` = 1: the first duty step occurs at the first `step_tick` at or after k+2.
- Full-scale fade is `PWM_MAX` steps, i.e. `PWM_MAX` × STEP_DIV cycles (default 255 × 50000).
- `fade_en` falling mid-ramp: duty reaches target on the next cycle.
- `fade_en` rising: ramping begins on the next `step_tick`; the prescaler is not reset.
- `busy` rises within 2 cycles of a `level` change that alters any target. It falls on the cycle after the last channel's duty equals its target.
- A duty update and a `pwm_cnt` wrap in the same cycle are legal. The new duty applies from the following cycle's compare, so glitch-free operation is not required within a period.

## Structure
- Shared package `nios_led_pkg` holds:
  - `PWM_BITS` default and the `PWM_MAX` function/constant.
  - The channel state enum (IDLE_OFF, RISING, IDLE_ON, FALLING), exported for debug/assertions.
- One sub-module, `nios_led_fader_channel`: owns the duty register, ramp logic, PWM compare and `led` flop for one channel.
  - Inputs: `step_tick`, `pwm_cnt`, `fade_en`, target bit.
  - Outputs: `led`, `ne` (duty ≠ target).
- The top level owns `level_q`, the prescaler, `pwm_cnt`, the `busy` OR, and a generate loop over CHANNELS.

## Test plan
All scenarios use STEP_DIV = 4, PWM_BITS = 8 (`PWM_MAX` = 255).
- **Reset:** assert `reset` mid-simulation with `level` = 4'hF, fading → `led` = 0, `busy` = 0 in the same cycle; all duties read 0.
- **Fade up:** `fade_en` = 1, `level` 0→4'b0001 → `busy` = 1 within 2 cycles; ch0 duty reaches 255 after 255 ticks (~1020 cycles); `led[0]` constantly 1 afterwards; `busy` = 0; other channels stay 0.
- **Mid-ramp reversal:** ch1 rising; drop `level[1]` at duty 100 → duty falls 100→0 over 100 ticks with no jump; monotonic sequence checked.
- **Bypass:** `fade_en` = 0, `level` 0→4'hA → duties {255, 0, 255, 0} exactly 2 cycles after the edge; `busy` never stays high beyond 2 cycles.
- **PWM ratio:** force duty 64 on ch2 (`fade_en` = 0 after ramping, or via a ramp stop) → `led[2]` high for exactly 64 of every 255 cycles across 3 periods.
- **Saturation:** hold `level` = 4'hF for 2× full fade time → duty stays 255 with no wrap to 0; the same check with `level` = 0 confirms duty stays 0.

Source files
------------

// File: rtl/nios_led_pkg.sv
// Shared types and helpers for the LED PWM fader: default duty width, full-scale duty
// and the per-channel fade state derived from duty versus target.
package nios_led_pkg;

  localparam int unsigned PwmBitsDefault = 8;

  typedef enum logic [1:0] {
    StIdleOff,
    StRising,
    StIdleOn,
    StFalling
  } chan_state_e;

  function automatic int unsigned pwm_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic chan_state_e chan_state(input int unsigned duty, input logic target,
                                             input int unsigned duty_max);
    if (target) begin
      return (duty == duty_max) ? StIdleOn : StRising;
    end
    return (duty == 0) ? StIdleOff : StFalling;
  endfunction

endpackage

// File: rtl/nios_led_fader_channel.sv
// One LED channel: duty register ramped toward an on/off target, PWM compare and
// registered pin drive.
module nios_led_fader_channel
  import nios_led_pkg::*;
#(
  parameter int unsigned PWM_BITS = PwmBitsDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                step_tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                fade_en_i,
  input  logic                target_i,
  output logic                led_o,
  output logic                ne_o
);

  localparam int unsigned PwmMax = pwm_max(PWM_BITS);
  localparam logic [PWM_BITS-1:0] DutyMax = PWM_BITS'(PwmMax);

  logic [PWM_BITS-1:0] duty_q, duty_d, target_duty;
  logic                led_q;
  chan_state_e         state_d;

  assign target_duty = target_i ? DutyMax : '0;

  // Targets are always 0 or full scale, so stepping toward them cannot wrap.
  always_comb begin
    duty_d = duty_q;
    if (!fade_en_i) begin
      duty_d = target_duty;
    end else if (step_tick_i) begin
      if (duty_q < target_duty) begin
        duty_d = duty_q + PWM_BITS'(1);
      end else if (duty_q > target_duty) begin
        duty_d = duty_q - PWM_BITS'(1);
      end
    end
  end

  assign state_d = chan_state(32'(duty_d), target_i, PwmMax);
  assign ne_o    = (state_d == StRising) || (state_d == StFalling);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= (pwm_cnt_i < duty_q);
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/nios_basic_led_fader.sv
// PWM fader behind the 4-bit LED PIO: turns each on/off bit change into a linear
// brightness ramp, with a shared step prescaler and PWM counter.
module nios_basic_led_fader
  import nios_led_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PWM_BITS = PwmBitsDefault,
  parameter int unsigned STEP_DIV = 50000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] level_i,
  input  logic                fade_en_i,
  output logic [CHANNELS-1:0] led_o,
  output logic                busy_o
);

  localparam int unsigned PwmMax = pwm_max(PWM_BITS);
  localparam int unsigned PsW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PsW-1:0]      PsLast  = PsW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] CntLast = PWM_BITS'(PwmMax - 1);

  logic [CHANNELS-1:0] level_q, ne;
  logic [PsW-1:0]      ps_q, ps_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                step_tick, busy_q;

  // With STEP_DIV == 1 the counter sits at 0 and ticks every cycle.
  assign step_tick = (ps_q == PsLast);
  assign ps_d      = step_tick ? '0 : ps_q + PsW'(1);

  // Period of PwmMax cycles so full-scale duty is a constant high.
  assign pwm_cnt_d = (pwm_cnt_q == CntLast) ? '0 : pwm_cnt_q + PWM_BITS'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q   <= '0;
      ps_q      <= '0;
      pwm_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      level_q   <= level_i;
      ps_q      <= ps_d;
      pwm_cnt_q <= pwm_cnt_d;
      busy_q    <= |ne;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    nios_led_fader_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .step_tick_i(step_tick),
      .pwm_cnt_i  (pwm_cnt_q),
      .fade_en_i  (fade_en_i),
      .target_i   (level_q[i]),
      .led_o      (led_o[i]),
      .ne_o       (ne[i])
    );
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_nios_basic_led_fader.sv
// Scoreboard bench for nios_basic_led_fader with STEP_DIV = 4, PWM_BITS = 8.
module tb_nios_basic_led_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] level;
  logic       fade_en;
  logic [3:0] led;
  logic       busy;
  logic [7:0] duty [4];

  nios_basic_led_fader #(
    .CHANNELS(4),
    .PWM_BITS(8),
    .STEP_DIV(4)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .level_i  (level),
    .fade_en_i(fade_en),
    .led_o    (led),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  assign duty[0] = dut.g_ch[0].u_ch.duty_q;
  assign duty[1] = dut.g_ch[1].u_ch.duty_q;
  assign duty[2] = dut.g_ch[2].u_ch.duty_q;
  assign duty[3] = dut.g_ch[3].u_ch.duty_q;

  typedef struct {
    string tag;
    int    exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input int exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input int obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", obs, -1);
    end else begin
      it = sb_q.pop_front();
      check_val(it.tag, obs, it.exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, prev, viol, lo_cnt, hi_cnt, maxv, decs, busy_hi, hits;
    int pv [4];
    bit seen;

    // Power-on reset
    rst = 1'b1; level = '0; fade_en = 1'b0;
    repeat (3) @(negedge clk);
    sb_push("rst_led", 0);
    sb_push("rst_busy", 0);
    for (int i = 0; i < 4; i++) sb_push("rst_duty", 0);
    sb_pop(int'(led));
    sb_pop(int'(busy));
    for (int i = 0; i < 4; i++) sb_pop(int'(duty[i]));

    // Asynchronous reset in the middle of a fade
    rst = 1'b0; level = 4'hF; fade_en = 1'b1;
    sb_push("prerst_busy", 1);
    repeat (50) @(negedge clk);
    sb_pop(int'(busy));
    sb_push("arst_led", 0);
    sb_push("arst_busy", 0);
    for (int i = 0; i < 4; i++) sb_push("arst_duty", 0);
    #2 rst = 1'b1; level = 4'h0;
    #1;
    sb_pop(int'(led));
    sb_pop(int'(busy));
    for (int i = 0; i < 4; i++) sb_pop(int'(duty[i]));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Fade up on channel 0
    level = 4'b0001;
    sb_push("up_busy_2cyc", 1);
    sb_push("up_step_viol", 0);
    sb_push("up_reach_time", 1);
    seen = 0; viol = 0; n = 0; prev = int'(duty[0]);
    while (n < 1100 && duty[0] != 8'd255) begin
      @(negedge clk);
      n++;
      if (n <= 2 && busy) seen = 1;
      if (!(int'(duty[0]) == prev || int'(duty[0]) == prev + 1)) viol++;
      prev = int'(duty[0]);
    end
    sb_pop(int'(seen));
    sb_pop(viol);
    sb_pop(int'(n >= 1018 && n <= 1021));
    sb_push("up_led0_low", 0);
    sb_push("up_other_led_hi", 0);
    sb_push("up_busy_done", 0);
    for (int i = 1; i < 4; i++) sb_push("up_other_duty", 0);
    repeat (2) @(negedge clk);
    lo_cnt = 0; hi_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (!led[0]) lo_cnt++;
      if (led[3:1] != 3'b000) hi_cnt++;
    end
    sb_pop(lo_cnt);
    sb_pop(hi_cnt);
    sb_pop(int'(busy));
    for (int i = 1; i < 4; i++) sb_pop(int'(duty[i]));

    // Channel 1 rising, reversed at duty 100
    level = 4'b0011;
    sb_push("rev_found100", 1);
    n = 0;
    while (n < 500 && duty[1] != 8'd100) begin
      @(negedge clk);
      n++;
    end
    level = 4'b0001;
    sb_pop(int'(duty[1] == 8'd100));
    sb_push("rev_max", 100);
    sb_push("rev_viol", 0);
    sb_push("rev_decs", 100);
    sb_push("rev_final", 0);
    maxv = int'(duty[1]); prev = maxv; viol = 0; decs = 0; n = 0;
    while (n < 450 && duty[1] != 8'd0) begin
      @(negedge clk);
      n++;
      if (int'(duty[1]) > maxv) maxv = int'(duty[1]);
      if (int'(duty[1]) == prev - 1) decs++;
      else if (int'(duty[1]) != prev) viol++;
      prev = int'(duty[1]);
    end
    sb_pop(maxv);
    sb_pop(viol);
    sb_pop(decs);
    sb_pop(int'(duty[1]));

    // Bypass: duty jumps to target two cycles after the edge
    fade_en = 1'b0; level = 4'hA; busy_hi = 0;
    sb_push("byp_k1_duty1", 0);
    sb_push("byp_k2_duty0", 0);
    sb_push("byp_k2_duty1", 255);
    sb_push("byp_k2_duty2", 0);
    sb_push("byp_k2_duty3", 255);
    sb_push("byp_k3_led", 4'hA);
    sb_push("byp_busy_short", 1);
    @(negedge clk);
    if (busy) busy_hi++;
    sb_pop(int'(duty[1]));
    @(negedge clk);
    if (busy) busy_hi++;
    for (int i = 0; i < 4; i++) sb_pop(int'(duty[i]));
    @(negedge clk);
    if (busy) busy_hi++;
    sb_pop(int'(led));
    repeat (3) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    sb_pop(int'(busy_hi <= 2));

    // PWM ratio at duty 64 on channel 2
    level = 4'b0100;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 3; p++) sb_push("pwm_period_hits", 64);
    force dut.g_ch[2].u_ch.duty_q = 8'd64;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      hits = 0;
      repeat (255) begin
        @(negedge clk);
        if (led[2]) hits++;
      end
      sb_pop(hits);
    end
    release dut.g_ch[2].u_ch.duty_q;
    sb_push("pwm_release_duty2", 255);
    repeat (3) @(negedge clk);
    sb_pop(int'(duty[2]));

    // Saturation at full scale, then at zero
    fade_en = 1'b1; level = 4'hF; viol = 0;
    sb_push("sat_hi_viol", 0);
    for (int i = 0; i < 4; i++) sb_push("sat_hi_duty", 255);
    for (int i = 0; i < 4; i++) pv[i] = int'(duty[i]);
    repeat (2060) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (int'(duty[i]) < pv[i]) viol++;
        pv[i] = int'(duty[i]);
      end
    end
    sb_pop(viol);
    for (int i = 0; i < 4; i++) sb_pop(int'(duty[i]));

    level = 4'h0; viol = 0;
    sb_push("sat_lo_viol", 0);
    for (int i = 0; i < 4; i++) sb_push("sat_lo_duty", 0);
    sb_push("sat_lo_busy", 0);
    sb_push("sat_lo_led", 0);
    repeat (2060) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (int'(duty[i]) > pv[i]) viol++;
        pv[i] = int'(duty[i]);
      end
    end
    sb_pop(viol);
    for (int i = 0; i < 4; i++) sb_pop(int'(duty[i]));
    sb_pop(int'(busy));
    sb_pop(int'(led));

    check_val("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
